// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, ROM address generation and a small fetch queue to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise fetch_misalign.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instr_rAddr,
  input  logic [31:0] instr_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int              PW      = $clog2(FQ_DEPTH);
  localparam logic [PW:0]     DEPTH_C = FQ_DEPTH[PW:0];
  localparam logic [31:0]     ALIGN_M = 32'hFFFF_FFFC;

  logic [31:0]   pc, pc_nxt;
  logic [PW:0]   count, count_nxt;
  logic [PW-1:0] rd_ptr, rd_nxt, wr_ptr, wr_nxt;
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [31:0]   redirect_target;
  logic          halted, push, pop;

  // fd handshake: the head transfers on any cycle where fd_valid && fd_ready;
  // fd_* hold while fd_valid && !fd_ready unless a redirect flushes the queue.
  assign instr_rAddr = pc;
  assign fd_valid    = (count != '0);
  assign fd_instr    = q_instr[rd_ptr];
  assign fd_pc       = q_pc[rd_ptr];
  assign fd_pc_plus4 = fd_pc + 32'd4;

  assign pop  = fd_valid && fd_ready;
  assign push = !redirect_valid && !halted && ((count < DEPTH_C) || pop);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q;

  always_comb begin
    redirect_target = redirect_pc & ALIGN_M;
    if (redirect_pc[1:0] != 2'b00) redirect_target = redirect_pc;
  end

  // Sticky: once a misaligned target is taken, only reset restarts fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      halted_q <= 1'b1;
    end
  end

  assign halted         = halted_q;
  assign fetch_misalign = halted_q;
`else
  always_comb begin
    redirect_target = redirect_pc & ALIGN_M;
  end

  assign halted = 1'b0;
`endif

  // A redirect wins over a simultaneous pop; the popped head is simply dropped with the flush.
  always_comb begin
    pc_nxt    = pc;
    count_nxt = count;
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    if (redirect_valid) begin
      pc_nxt    = redirect_target;
      count_nxt = '0;
      rd_nxt    = '0;
      wr_nxt    = '0;
    end else begin
      if (push) begin
        pc_nxt = pc + 32'd4;
        wr_nxt = wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_nxt = rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_nxt = count + 1'b1;
      end else if (pop && !push) begin
        count_nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      pc     <= pc_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
    end
  end

  // Storage is cleared on reset so the head outputs read 0 / 0 / 4 while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= instr_code;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a ROM returning word n = n, a scoreboard of expected {pc, instr},
// and a second instance with RESET_PC near the top of the address space.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_rAddr, instr_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fd_valid, fd_ready;
  logic [31:0] fd_instr, fd_pc, fd_pc_plus4;

  logic [31:0] instr_rAddr2, instr_code2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        fd_valid2, fd_ready2;
  logic [31:0] fd_instr2, fd_pc2, fd_pc_plus42;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misalign, fetch_misalign2;
`endif

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign instr_code  = instr_rAddr >> 2;
  assign instr_code2 = instr_rAddr2 >> 2;

  instr_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_rAddr    (instr_rAddr),
    .instr_code     (instr_code),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
    .fd_pc_plus4    (fd_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_rAddr    (instr_rAddr2),
    .instr_code     (instr_code2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .fd_valid       (fd_valid2),
    .fd_ready       (fd_ready2),
    .fd_instr       (fd_instr2),
    .fd_pc          (fd_pc2),
    .fd_pc_plus4    (fd_pc_plus42)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + 32'(4 * i);
      exp_q.push_back({p, p >> 2});
    end
  endtask

  // Called on a falling edge with fd_ready = 1: one head must be delivered every cycle.
  task automatic drain(input int n);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check("drain_valid", 64'(fd_valid), 64'd1);
      check("drain_head", {fd_pc, fd_instr}, e);
      check("drain_plus4", 64'(fd_pc_plus4), 64'(e[63:32] + 32'd4));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    fd_ready       = 1'b1;
    fd_ready2      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(fd_valid), 64'd0);
    check("rst_instr", 64'(fd_instr), 64'd0);
    check("rst_pc", 64'(fd_pc), 64'd0);
    check("rst_plus4", 64'(fd_pc_plus4), 64'd4);
    check("rst_raddr", 64'(instr_rAddr), 64'h0);
    check("rst_raddr2", 64'(instr_rAddr2), 64'hFFFF_FFF8);

    // Release: first push on the first rising edge, then one instruction per cycle
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_valid", 64'(fd_valid), 64'd1);
    expect_seq(32'h0, 6);
    drain(6);

    // Second instance stalled from the start: wraps past the top and holds at 0
    check("wrap_stall_pc", 64'(instr_rAddr2), 64'h0);
    check("wrap_count", 64'(dut2.count), 64'd2);
    fd_ready2 = 1'b1;
    check("wrap_pc0", {fd_pc2, fd_instr2}, {32'hFFFF_FFF8, 32'h3FFF_FFFE});
    @(negedge clk);
    check("wrap_pc1", {fd_pc2, fd_instr2}, {32'hFFFF_FFFC, 32'h3FFF_FFFF});
    check("wrap_plus4", 64'(fd_pc_plus42), 64'h0);
    @(negedge clk);
    check("wrap_pc2", {fd_pc2, fd_instr2}, {32'h0, 32'h0});
    check("wrap_valid2", 64'(fd_valid2), 64'd1);

    // Back-pressure after reset: fill to depth, PC stalls at 8, then drain with no gap
    fd_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    check("fill_count", 64'(dut.count), 64'd2);
    check("fill_pc", 64'(instr_rAddr), 64'h8);
    check("fill_head", 64'(fd_pc), 64'h0);
    fd_ready = 1'b1;
    expect_seq(32'h0, 4);
    drain(4);

    // Redirect to 0x40 with the queue full and pop high
    fd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("full_count", 64'(dut.count), 64'd2);
    fd_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("flush_valid", 64'(fd_valid), 64'd0);
    check("flush_count", 64'(dut.count), 64'd0);
    check("redir_raddr", 64'(instr_rAddr), 64'h40);
    @(negedge clk);
    check("redir_valid", 64'(fd_valid), 64'd1);
    check("redir_plus4", 64'(fd_pc_plus4), 64'h44);
    expect_seq(32'h40, 3);
    drain(3);

    // Misaligned redirect to 0x42
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_raddr", 64'(instr_rAddr), 64'h42);
    for (int i = 0; i < 4; i++) begin
      check("mis_flag", 64'(fetch_misalign), 64'd1);
      check("mis_valid", 64'(fd_valid), 64'd0);
      @(negedge clk);
    end
    do_reset();
    check("mis_cleared", 64'(fetch_misalign), 64'd0);
    @(negedge clk);
    expect_seq(32'h0, 2);
    drain(2);
`else
    check("mis_raddr", 64'(instr_rAddr), 64'h40);
    check("mis_valid0", 64'(fd_valid), 64'd0);
    @(negedge clk);
    expect_seq(32'h40, 2);
    drain(2);
`endif

    // Asynchronous reset between edges with a full queue
    fd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("async_pre_valid", 64'(fd_valid), 64'd1);
    check("async_pre_count", 64'(dut.count), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 64'(fd_valid), 64'd0);
    check("async_raddr", 64'(instr_rAddr), 64'h0);
    check("async_count", 64'(dut.count), 64'd0);
    check("async_pc", 64'(fd_pc), 64'h0);
    check("async_raddr2", 64'(instr_rAddr2), 64'hFFFF_FFF8);
    @(negedge clk);
    fd_ready = 1'b1;
    reset_n  = 1'b1;
    @(negedge clk);
    expect_seq(32'h0, 2);
    drain(2);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
